clb_cfg_loader: RTL
===================

// Module: clb_cfg_loader
// PURPOSE
//  Serial configuration loader for one CLB: hunts a preamble, shifts in a CFG_W-bit frame
//  plus even parity, then commits it atomically to the CLB configuration bus.
//  Replaces power-on hard-coded CLB settings with a runtime bitstream; one instance per CLB in the array chain.
// PARAMETERS
//  CFG_W    37     frame data width (CLB config bits)
//  PREAMBLE 8'hF2  sync pattern, MSB first
// PORTS
//  K          in   1      clock, rising edge
//  RSTN       in   1      synchronous active-low reset
//  DIN        in   1      serial config data, MSB first
//  DIN_VALID  in   1      DIN sampled only when 1
//  CFG        out  CFG_W  committed config (layout below)
//  CFG_VALID  out  1      sticky: a frame has been committed since reset
//  DONE       out  1      1-cycle pulse on commit
//  ERR        out  1      sticky parity error; cleared by reset or next good commit
//  BUSY       out  1      1 in LOAD/PARITY
//  RB_REQ     in   1      readback request (READBACK_EN only)
//  DOUT       out  1      readback serial data, MSB first
//  DOUT_VALID out  1      readback bit strobe
// BEHAVIOUR
//  CFG layout: [36:21] lut mem[15:0]; [20:19] comboption; [18:17] S sel; [16:15] clk sel;
//   [14:13] R sel; [12:11] X sel; [10:9] Y sel; [8:6] o2m{1,2,3}_0; [5:3] o2m{1,2,3}_1;
//   [2:1] DQmux{1,2}; [0] floporlatch.
//  Reset (RSTN=0 at edge): CFG=default (mem=16'h0116, comboption=00, S/clk/R sel=10,
//   X/Y sel=00, o2m_0=000, o2m_1=111, DQmux=00, floporlatch=0); CFG_VALID=0, DONE=0,
//   ERR=0, BUSY=0, DOUT=0, DOUT_VALID=0; state=IDLE; preamble/shadow/counters cleared.
//  DIN_VALID=0: full stall, no state/counter/shift change; DONE stays 0.
//  FSM IDLE: each valid bit shifts into 8-bit hunt reg; when {hunt[6:0],DIN}==PREAMBLE
//   -> LOAD, bit count=0. Overlapping patterns allowed.
//  LOAD: each valid bit shifts into shadow reg, count++; bit CFG_W-1 accepted -> PARITY.
//   Preamble pattern inside payload is data, not resync.
//  PARITY: valid bit p; if XOR(shadow,p)==0 -> CFG<=shadow, DONE=1 for the cycle after the
//   sampling edge (same edge CFG updates), CFG_VALID<=1, ERR<=0; else ERR<=1, CFG unchanged.
//   Either way -> IDLE, hunt reg cleared.
//  Latency: parity bit sampled at edge n -> CFG/DONE visible after edge n.
//  Reset mid-frame: shadow discarded, all outputs to reset values, no DONE.
//  CFG never changes except on commit or reset (no partial updates visible to CLB).
// CONFIGURATION
//  CLB_CFG_READBACK_EN defined: RB_REQ=1 while readback idle snapshots CFG into rb shift reg;
//   DOUT_VALID=1 for exactly CFG_W consecutive cycles starting the cycle after request,
//   DOUT = CFG[CFG_W-1] first. RB_REQ ignored while active; commit during readback does not
//   alter in-flight snapshot. Reset aborts readback.
//  Undefined: RB_REQ ignored, DOUT=0, DOUT_VALID=0, no readback logic; ports remain.
// TESTING
//  1 RSTN=0 two cycles -> CFG=default above, CFG_VALID=0, ERR=0, BUSY=0.
//  2 DIN=F2, 37-bit frame mem=16'h8000 rest 0, parity=1 -> DONE one cycle, CFG[36]=1 only, CFG_VALID=1.
//  3 Same frame, parity=0 -> ERR=1, no DONE, CFG keeps prior value; next good frame clears ERR.
//  4 Good frame with DIN_VALID=0 every other cycle -> identical CFG to 2, DONE 1 cycle only.
//  5 RSTN=0 after 20 payload bits -> CFG=default, BUSY=0; fresh frame then loads correctly.
//  6 (READBACK_EN) after 2, RB_REQ pulse -> 37 DOUT_VALID cycles, DOUT seq 1 then 36 zeros.

Source files
------------

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: preamble hunt, CFG_W-bit frame plus even parity, atomic commit.
// Optional readback shifter enabled by defining CLB_CFG_READBACK_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | hunting for the preamble in the valid bit stream
// ST_LOAD   | shifting payload bits into the shadow register
// ST_PARITY | next valid bit is the parity; commit or flag an error
module clb_cfg_loader #(
  parameter int          CFG_W    = 37,
  parameter logic [7:0]  PREAMBLE = 8'hF2
) (
  input  logic             K,
  input  logic             RSTN,
  input  logic             DIN,
  input  logic             DIN_VALID,
  output logic [CFG_W-1:0] CFG,
  output logic             CFG_VALID,
  output logic             DONE,
  output logic             ERR,
  output logic             BUSY,
  input  logic             RB_REQ,
  output logic             DOUT,
  output logic             DOUT_VALID
);

  localparam int CNT_W = $clog2(CFG_W);

  // Power-on CLB settings: mem 0116, S/clk/R sel 10, o2m_1 111, everything else 0.
  localparam logic [CFG_W-1:0] CFG_DEFAULT = CFG_W'({16'h0116, 2'b00, 2'b10, 2'b10, 2'b10,
                                                     2'b00, 2'b00, 3'b000, 3'b111, 2'b00, 1'b0});

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       hunt;
  logic [CFG_W-1:0] shadow;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       hunt_next;

  assign hunt_next = {hunt[6:0], DIN};

  always_ff @(posedge K) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      hunt      <= '0;
      shadow    <= '0;
      bit_cnt   <= '0;
      CFG       <= CFG_DEFAULT;
      CFG_VALID <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (DIN_VALID) begin
        case (state)
          ST_IDLE: begin
            hunt <= hunt_next;
            if (hunt_next == PREAMBLE) begin
              state   <= ST_LOAD;
              bit_cnt <= CNT_W'(CFG_W - 1);
              BUSY    <= 1'b1;
            end
          end
          ST_LOAD: begin
            // Down-counter terminal count marks the last payload bit.
            shadow <= {shadow[CFG_W-2:0], DIN};
            if (bit_cnt == '0) begin
              state <= ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          ST_PARITY: begin
            if ((^shadow ^ DIN) == 1'b0) begin
              CFG       <= shadow;
              CFG_VALID <= 1'b1;
              DONE      <= 1'b1;
              ERR       <= 1'b0;
            end else begin
              ERR <= 1'b1;
            end
            state <= ST_IDLE;
            hunt  <= '0;
            BUSY  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            hunt  <= '0;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CLB_CFG_READBACK_EN
  logic             rb_active;
  logic [CFG_W-1:0] rb_sh;
  logic [CNT_W-1:0] rb_cnt;

  // The snapshot is taken from the committed register, so a commit on the
  // same edge or later never disturbs a readback in flight.
  always_ff @(posedge K) begin
    if (!RSTN) begin
      rb_active  <= 1'b0;
      rb_sh      <= '0;
      rb_cnt     <= '0;
      DOUT       <= 1'b0;
      DOUT_VALID <= 1'b0;
    end else if (!rb_active) begin
      if (RB_REQ) begin
        rb_active  <= 1'b1;
        rb_sh      <= {CFG[CFG_W-2:0], 1'b0};
        rb_cnt     <= CNT_W'(CFG_W - 1);
        DOUT       <= CFG[CFG_W-1];
        DOUT_VALID <= 1'b1;
      end
    end else if (rb_cnt == '0) begin
      rb_active  <= 1'b0;
      DOUT       <= 1'b0;
      DOUT_VALID <= 1'b0;
    end else begin
      rb_sh  <= {rb_sh[CFG_W-2:0], 1'b0};
      rb_cnt <= rb_cnt - 1'b1;
      DOUT   <= rb_sh[CFG_W-1];
    end
  end
`else
  // RB_REQ has no function without readback; the AND keeps the port referenced.
  assign DOUT       = RB_REQ & 1'b0;
  assign DOUT_VALID = 1'b0;
`endif

endmodule
